// File: rtl/sort_controller_pkg.sv
// sort_pkg: shared definitions for the 8-entry exchange-sort controller.
//   sort_state_t  : 4-bit Moore state encoding (12 legal states)
//   SORT_PAIRS    : number of (i,j) compare pairs for N=8
//   SORT_BASE_CYC : busy cycles of a run with no swaps
package sort_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT_J = 4'd1,
        S_RD_A   = 4'd2,
        S_LD_A   = 4'd3,
        S_RD_B   = 4'd4,
        S_LD_B   = 4'd5,
        S_CMP    = 4'd6,
        S_SWAP_I = 4'd7,
        S_SWAP_J = 4'd8,
        S_NEXT_J = 4'd9,
        S_NEXT_I = 4'd10,
        S_DONE   = 4'd11
    } sort_state_t;

    localparam int unsigned SORT_PAIRS    = 28;
    localparam int unsigned SORT_BASE_CYC = 183;

endpackage

// File: rtl/sort_controller_if.sv
// sort_controller_if: handshake and datapath-control bundle of the sort
// controller.
//   slave  : controller side (takes host requests and datapath flags,
//            drives datapath enables, RAM control and status)
//   master : host/datapath side
interface sort_controller_if;

    // host side
    logic start;
    logic host_wr;
    logic host_rd;
    // datapath flags
    logic AgtB;
    logic zi;
    logic zj;
    // datapath control
    logic EA;
    logic EB;
    logic WR;
    logic Li;
    logic Ei;
    logic Lj;
    logic Ej;
    logic Csel;
    logic Bout;
    logic s;
    logic Rd;
    // status
    logic busy;
    logic done;

    modport slave (
        input  start, host_wr, host_rd, AgtB, zi, zj,
        output EA, EB, WR, Li, Ei, Lj, Ej, Csel, Bout, s, Rd, busy, done
    );

    modport master (
        output start, host_wr, host_rd, AgtB, zi, zj,
        input  EA, EB, WR, Li, Ei, Lj, Ej, Csel, Bout, s, Rd, busy, done
    );

endinterface

// File: rtl/sort_controller.sv
// sort_controller: Moore FSM sequencing an 8-entry in-place exchange sort
// on the byte-sort datapath, and sharing the RAM port with the host while
// idle.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : sort_controller_if.slave (host start/wr/rd, datapath flags in;
//         datapath enables, RAM control, busy/done out)
module sort_controller
    import sort_pkg::*;
(
    input logic             clk,
    input logic             rst,
    sort_controller_if.slave bus
);

    sort_state_t r_state;
    sort_state_t w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = S_IDLE;
        bus.EA   = 1'b0;
        bus.EB   = 1'b0;
        bus.WR   = 1'b0;
        bus.Li   = 1'b0;
        bus.Ei   = 1'b0;
        bus.Lj   = 1'b0;
        bus.Ej   = 1'b0;
        bus.Csel = 1'b0;
        bus.Bout = 1'b0;
        bus.s    = 1'b0;
        bus.Rd   = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;

        // IDLE outputs pass host inputs straight through, so reset must
        // gate them explicitly rather than rely on the state register.
        if (rst) begin
            bus.busy = (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    bus.WR = bus.host_wr;
                    bus.Rd = bus.host_rd;
                    if (bus.start) begin
                        bus.Li = 1'b1;
                        w_next = S_INIT_J;
                    end
                end
                S_INIT_J: begin
                    bus.s  = 1'b1;
                    bus.Lj = 1'b1;
                    w_next = S_RD_A;
                end
                S_RD_A: begin
                    bus.s  = 1'b1;
                    w_next = S_LD_A;
                end
                S_LD_A: begin
                    bus.s  = 1'b1;
                    bus.EA = 1'b1;
                    w_next = S_RD_B;
                end
                S_RD_B: begin
                    bus.s    = 1'b1;
                    bus.Csel = 1'b1;
                    w_next   = S_LD_B;
                end
                S_LD_B: begin
                    bus.s    = 1'b1;
                    bus.Csel = 1'b1;
                    bus.EB   = 1'b1;
                    w_next   = S_CMP;
                end
                S_CMP: begin
                    bus.s  = 1'b1;
                    w_next = bus.AgtB ? S_SWAP_I : S_NEXT_J;
                end
                S_SWAP_I: begin
                    bus.s    = 1'b1;
                    bus.Bout = 1'b1;
                    bus.WR   = 1'b1;
                    w_next   = S_SWAP_J;
                end
                S_SWAP_J: begin
                    bus.s    = 1'b1;
                    bus.Csel = 1'b1;
                    bus.WR   = 1'b1;
                    w_next   = S_NEXT_J;
                end
                S_NEXT_J: begin
                    bus.s = 1'b1;
                    if (bus.zj) begin
                        w_next = S_NEXT_I;
                    end else begin
                        bus.Ej = 1'b1;
                        w_next = S_RD_A;
                    end
                end
                S_NEXT_I: begin
                    bus.s = 1'b1;
                    if (bus.zi) begin
                        w_next = S_DONE;
                    end else begin
                        bus.Ei = 1'b1;
                        w_next = S_INIT_J;
                    end
                end
                S_DONE: begin
                    bus.done = 1'b1;
                    w_next   = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_controller.sv
// tb_sort_controller: drives sort_controller against a behavioural model of
// the 8-entry byte datapath and RAM, and checks results against a plain
// exchange-sort reference.
module tb_sort_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] Radd;
    logic [7:0] Datain;
    logic [7:0] DataOut;

    sort_controller_if ifc ();

    sort_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // ---------------- datapath model ----------------
    logic [7:0] mem [8];
    logic [7:0] regA, regB;
    logic [2:0] di, dj;
    logic [2:0] addr;
    logic [7:0] wdata;

    assign addr     = ifc.s ? (ifc.Csel ? dj : di) : Radd;
    assign wdata    = ifc.s ? (ifc.Bout ? regB : regA) : Datain;
    assign DataOut  = ifc.Rd ? mem[addr] : 8'hzz;
    assign ifc.AgtB = (regA > regB);
    assign ifc.zi   = (di == 3'd6);
    assign ifc.zj   = (dj == 3'd7);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            regA <= '0; regB <= '0; di <= '0; dj <= '0;
        end else begin
            if (ifc.Li) di <= 3'd0;
            else if (ifc.Ei) di <= di + 3'd1;
            if (ifc.Lj) dj <= di + 3'd1;
            else if (ifc.Ej) dj <= dj + 3'd1;
            if (ifc.EA) regA <= mem[addr];
            if (ifc.EB) regB <= mem[addr];
        end
    end

    always @(posedge clk) begin
        if (ifc.WR) mem[addr] <= wdata;
    end

    // ---------------- reference and checking ----------------
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  ref_in  [8];
    logic [7:0]  exp_out [8];
    int unsigned exp_swaps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] outvec();
        return {ifc.EA, ifc.EB, ifc.WR, ifc.Li, ifc.Ei, ifc.Lj, ifc.Ej,
                ifc.Csel, ifc.Bout, ifc.s, ifc.Rd, ifc.busy, ifc.done};
    endfunction

    task automatic ref_model();
        logic [7:0] t;
        exp_swaps = 0;
        for (int k = 0; k < 8; k++) exp_out[k] = ref_in[k];
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 8; j++)
                if (exp_out[i] > exp_out[j]) begin
                    t = exp_out[i]; exp_out[i] = exp_out[j]; exp_out[j] = t;
                    exp_swaps++;
                end
    endtask

    task automatic clear_inputs();
        ifc.start = 1'b0; ifc.host_wr = 1'b0; ifc.host_rd = 1'b0;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        Radd = a; Datain = d; ifc.host_wr = 1'b1;
        #1 chk("idle_wr_pass", {31'd0, ifc.WR}, 32'd1);
        @(posedge clk);
        #1 ifc.host_wr = 1'b0;
    endtask

    task automatic host_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        Radd = a; ifc.host_rd = 1'b1;
        #1 d = DataOut;
        chk("idle_rd_pass", {31'd0, ifc.Rd}, 32'd1);
        ifc.host_rd = 1'b0;
        #1 chk("dataout_z", {24'd0, DataOut}, {24'd0, 8'hzz});
    endtask

    task automatic load_array();
        for (int k = 0; k < 8; k++) host_write(k[2:0], ref_in[k]);
    endtask

    task automatic verify_ram(input string tag);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) begin
            host_read(k[2:0], d);
            chk(tag, {24'd0, d}, {24'd0, exp_out[k]});
        end
    endtask

    // Starts a sort and watches it to completion. noise: toggle host inputs
    // randomly while busy. full: check cycle and write counts. with_wr:
    // issue host write of 0xFF to address 0 in the start cycle.
    task automatic run_sort(input string tag, input bit noise, input bit full, input bit with_wr);
        int unsigned cyc = 0, wrs = 0, rdb = 0, ndone = 0, donecyc = 0;
        @(negedge clk);
        ifc.start = 1'b1;
        if (with_wr) begin
            Radd = 3'd0; Datain = 8'hFF; ifc.host_wr = 1'b1;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        while (ifc.busy && cyc < 1000) begin
            cyc++;
            if (ifc.done) begin ndone++; donecyc = cyc; end
            if (ifc.WR) wrs++;
            if (ifc.Rd) rdb++;
            @(negedge clk);
            if (noise) begin
                ifc.start   = $urandom_range(0, 1) == 1;
                ifc.host_wr = $urandom_range(0, 1) == 1;
                ifc.host_rd = $urandom_range(0, 1) == 1;
                Datain      = 8'($urandom);
                Radd        = 3'($urandom);
            end
            #1;
        end
        clear_inputs();
        chk({tag, "_terminated"}, {31'd0, ifc.busy}, 32'd0);
        chk({tag, "_done_once"}, ndone, 32'd1);
        chk({tag, "_done_last"}, donecyc, cyc);
        chk({tag, "_rd_busy"}, rdb, 32'd0);
        if (full) begin
            chk({tag, "_busy_cyc"}, cyc, 183 + 2 * exp_swaps);
            chk({tag, "_wr_cnt"}, wrs, 2 * exp_swaps);
        end
        verify_ram(tag);
    endtask

    initial begin
        Radd = '0; Datain = '0;
        // reset with every host input high: all outputs must stay 0
        rst = 1'b0;
        ifc.start = 1'b1; ifc.host_wr = 1'b1; ifc.host_rd = 1'b1;
        #1 chk("reset_outputs", {19'd0, outvec()}, 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_outputs_held", {19'd0, outvec()}, 32'd0);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk); #1;
        chk("idle_state", {19'd0, outvec()}, 32'd0);

        // host load / readback with random data
        for (int k = 0; k < 8; k++) ref_in[k] = 8'($urandom);
        load_array();
        for (int k = 0; k < 8; k++) exp_out[k] = ref_in[k];
        verify_ram("host_readback");

        // sorted input: no swaps
        for (int k = 0; k < 8; k++) ref_in[k] = 8'(k);
        load_array(); ref_model();
        run_sort("sorted", 1'b0, 1'b1, 1'b0);

        // reversed input: every pair swaps
        for (int k = 0; k < 8; k++) ref_in[k] = 8'(7 - k);
        load_array(); ref_model();
        chk("reversed_ref_swaps", exp_swaps, 32'd28);
        run_sort("reversed", 1'b0, 1'b1, 1'b0);

        // duplicates: equal values never swap
        ref_in = '{8'd5, 8'd3, 8'd5, 8'd1, 8'd3, 8'd0, 8'd5, 8'd1};
        load_array(); ref_model();
        run_sort("dups", 1'b0, 1'b1, 1'b0);

        // random data with host noise during the run
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) ref_in[k] = 8'($urandom_range(0, 15));
            load_array(); ref_model();
            run_sort("rand_noise", 1'b1, 1'b1, 1'b0);
        end

        // reset mid-sort at cycle 50, then a fresh sort
        for (int k = 0; k < 8; k++) ref_in[k] = 8'($urandom);
        load_array(); ref_model();
        @(negedge clk); ifc.start = 1'b1;
        @(negedge clk); ifc.start = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b0;
        ifc.start = 1'b1; ifc.host_wr = 1'b1; ifc.host_rd = 1'b1;
        #1 chk("midsort_reset", {19'd0, outvec()}, 32'd0);
        chk("midsort_busy", {31'd0, ifc.busy}, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        run_sort("after_reset", 1'b0, 1'b0, 1'b0);

        // start together with a host write
        for (int k = 0; k < 8; k++) ref_in[k] = 8'($urandom_range(0, 200));
        load_array();
        ref_in[0] = 8'hFF; ref_model();
        run_sort("start_wr", 1'b0, 1'b1, 1'b1);
        chk("start_wr_ff_at_7", {24'd0, exp_out[7]}, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
